id_ex_pipe: RTL

ID_EX_PIPE -- requirements
Module: id_ex_pipe

---
 rtl/id_ex_pipe.sv | 116 +++++++++++
 1 files changed

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: captures decode controls and operands for the execute stage,
// with flush > stall > load priority. Optional counters under ID_EX_PERF_EN.
module id_ex_pipe #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [8:0]        ctl_in,
    input  logic [DATA_W-1:0] npc_in,
    input  logic [DATA_W-1:0] rd1_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [4:0]        rt_in,
    input  logic [4:0]        rd_in,
    output logic              valid_out,
    output logic [8:0]        ctl_out,
    output logic [DATA_W-1:0] npc_out,
    output logic [DATA_W-1:0] rd1_out,
    output logic [DATA_W-1:0] rd2_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [4:0]        rt_out,
    output logic [4:0]        rd_out,
    output logic [5:0]        funct_out,
    output logic              illegal_out
`ifdef ID_EX_PERF_EN
    ,
    output logic [15:0]       bubble_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    // valid_in qualifies the decode bundle on every load edge; there is no ready,
    // the upstream stage is held by the same stall that freezes this register.
    logic [1:0] alu_op_in;
    logic [5:0] funct_in;
    logic       funct_ok;
    logic       illegal_d;
    logic       load_en;

    assign alu_op_in = ctl_in[1:0];
    assign funct_in  = imm_in[5:0];
    assign load_en   = !flush && !stall;

    // R-type functs the ALU control understands: add, sub, and, or, slt.
    always_comb begin
        funct_ok = 1'b0;
        case (funct_in)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: funct_ok = 1'b1;
            default:                           funct_ok = 1'b0;
        endcase
    end

    assign illegal_d = valid_in &&
                       ((alu_op_in == 2'b11) || ((alu_op_in == 2'b10) && !funct_ok));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out   <= 1'b0;
            ctl_out     <= '0;
            illegal_out <= 1'b0;
            npc_out     <= '0;
            rd1_out     <= '0;
            rd2_out     <= '0;
            imm_out     <= '0;
            rt_out      <= '0;
            rd_out      <= '0;
            funct_out   <= '0;
        end else if (flush) begin
            valid_out   <= 1'b0;
            ctl_out     <= '0;
            illegal_out <= 1'b0;
            npc_out     <= '0;
            rd1_out     <= '0;
            rd2_out     <= '0;
            imm_out     <= '0;
            rt_out      <= '0;
            rd_out      <= '0;
            funct_out   <= '0;
        end else if (load_en) begin
            // Controls are zeroed for bubbles so valid_out=0 never carries side effects.
            valid_out   <= valid_in;
            ctl_out     <= valid_in ? ctl_in : 9'd0;
            illegal_out <= illegal_d;
            npc_out     <= npc_in;
            rd1_out     <= rd1_in;
            rd2_out     <= rd2_in;
            imm_out     <= imm_in;
            rt_out      <= rt_in;
            rd_out      <= rd_in;
            funct_out   <= funct_in;
        end
    end

`ifdef ID_EX_PERF_EN
    logic bubble_evt;
    logic stall_evt;

    assign bubble_evt = flush || (!stall && !valid_in);
    assign stall_evt  = stall && !flush;

    // Both counters saturate so long runs never read back as small numbers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (bubble_evt && (bubble_cnt != 16'hFFFF)) bubble_cnt <= bubble_cnt + 16'd1;
            if (stall_evt && (stall_cnt != 16'hFFFF))   stall_cnt  <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
